// File: rtl/theta_slice_engine.sv
// Keccak theta-step engine.
// Takes one state block as SLICES consecutive 25-bit slices. It applies theta while the
// slices are loaded. A single fix-up cycle (FIX0) then corrects slice 0, which needs
// the parity of the last slice. After that the buffered block is streamed out.
// Optional feature macro: THETA_BYPASS_EN adds a `bypass` input. When bypass is set,
// the block is passed through unmodified.
//
// state | meaning
// LOAD  | accepting input slices, theta applied on the fly (slice 0 stored raw)
// FIX0  | one cycle: apply the wrap-around theta term to slice 0
// OUT   | streaming buffered slices out with backpressure
module theta_slice_engine #(
  parameter  int SLICES = 64,
  localparam int ZW     = $clog2(SLICES)
) (
`ifdef THETA_BYPASS_EN
  input  logic          bypass,
`endif
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [24:0]   in_slice,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [24:0]   out_slice,
  output logic [ZW-1:0] out_idx,
  output logic          out_last,
  output logic          busy
);

  typedef enum logic [1:0] {LOAD, FIX0, OUT} state_t;

  localparam logic [ZW-1:0] LAST = ZW'(SLICES - 1);

  state_t        state;
  logic [ZW-1:0] wr_cnt;
  logic [ZW-1:0] rd_cnt;
  logic [4:0]    c0;
  logic [4:0]    cprev;
  logic          bypass_q;
  logic          bypass_in;
  logic [4:0]    col_par;
  logic [24:0]   wr_data;
  logic [24:0]   mem [SLICES];

`ifdef THETA_BYPASS_EN
  assign bypass_in = bypass;
`else
  assign bypass_in = 1'b0;
`endif

  // XOR of column x-1 of ca with column x+1 of cb, broadcast to all five rows
  function automatic logic [24:0] theta_mask(input logic [4:0] ca, input logic [4:0] cb);
    logic [4:0]  d;
    logic [24:0] m;
    for (int x = 0; x < 5; x++) d[x] = ca[(x + 4) % 5] ^ cb[(x + 1) % 5];
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++) m[5*y + x] = d[x];
    return m;
  endfunction

  // column parity of the incoming slice
  always_comb begin
    col_par = '0;
    for (int x = 0; x < 5; x++)
      col_par[x] = in_slice[x] ^ in_slice[x+5] ^ in_slice[x+10] ^ in_slice[x+15] ^ in_slice[x+20];
  end

  // slice 0 is stored raw; its theta term needs C[SLICES-1] and is applied in FIX0
  always_comb begin
    wr_data = in_slice;
    if (wr_cnt != '0 && !bypass_q) wr_data = in_slice ^ theta_mask(col_par, cprev);
  end

  // buffer writes: load beats, then the slice-0 fix-up
  always_ff @(posedge clk) begin
    if (state == LOAD && in_valid) mem[wr_cnt] <= wr_data;
    else if (state == FIX0 && !bypass_q) mem[0] <= mem[0] ^ theta_mask(c0, cprev);
  end

  // control FSM, counters and parity registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= LOAD;
      wr_cnt   <= '0;
      rd_cnt   <= '0;
      c0       <= '0;
      cprev    <= '0;
      bypass_q <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            wr_cnt <= wr_cnt + ZW'(1);
            cprev  <= col_par;
            if (wr_cnt == '0) begin
              c0       <= col_par;
              bypass_q <= bypass_in;
            end
            if (wr_cnt == LAST) state <= FIX0;
          end
        end
        FIX0: state <= OUT;
        OUT: begin
          if (out_ready) begin
            if (rd_cnt == LAST) begin
              rd_cnt <= '0;
              state  <= LOAD;
            end else begin
              rd_cnt <= rd_cnt + ZW'(1);
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  assign in_ready  = (state == LOAD);
  assign out_valid = (state == OUT);
  assign out_slice = mem[rd_cnt];
  assign out_idx   = rd_cnt;
  assign out_last  = (state == OUT) && (rd_cnt == LAST);
  assign busy      = (wr_cnt != '0) || (state != LOAD);

endmodule

// File: tb/tb_theta_slice_engine.sv
// Self-checking bench for theta_slice_engine (SLICES=64).
// The reference model computes theta directly over the whole block from column parities.
module tb_theta_slice_engine;
  localparam int SLICES = 64;
  localparam int ZW = $clog2(SLICES);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [24:0]   in_slice = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [24:0]   out_slice;
  logic [ZW-1:0] out_idx;
  logic          out_last;
  logic          busy;
  logic          bypass = 1'b0;

  int errors = 0;
  int checks = 0;

  logic [24:0] blk     [SLICES];
  logic [24:0] exp_blk [SLICES];

  theta_slice_engine #(.SLICES(SLICES)) dut (
`ifdef THETA_BYPASS_EN
    .bypass   (bypass),
`endif
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_slice (in_slice),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_slice(out_slice),
    .out_idx  (out_idx),
    .out_last (out_last),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic build_expected(input bit byp);
    logic [4:0] c [SLICES];
    for (int z = 0; z < SLICES; z++)
      for (int x = 0; x < 5; x++)
        c[z][x] = blk[z][x] ^ blk[z][x+5] ^ blk[z][x+10] ^ blk[z][x+15] ^ blk[z][x+20];
    for (int z = 0; z < SLICES; z++)
      for (int y = 0; y < 5; y++)
        for (int x = 0; x < 5; x++)
          exp_blk[z][5*y+x] = blk[z][5*y+x] ^
            (byp ? 1'b0 : (c[z][(x+4)%5] ^ c[(z+SLICES-1)%SLICES][(x+1)%5]));
  endtask

  task automatic send_beats(input int n, input bit gaps, input bit byp);
    int z = 0;
    int cyc = 0;
    bit hs;
    while (z < n && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_slice = blk[z];
      bypass   = byp;
      hs = in_valid && in_ready;
      @(posedge clk);
      if (hs) z++;
    end
    if (z < n) chk("tx_timeout", z, n);
  endtask

  task automatic run_block(input string name, input bit stall, input bit byp);
    int idx = 0;
    int cyc = 0;
    bit stalled = 0;
    logic [24:0]   h_slice;
    logic [ZW-1:0] h_idx;
    logic          h_last;
    build_expected(byp);
    send_beats(SLICES, stall, byp);
    @(negedge clk);
    in_valid = 1'b0;
    chk({name, "_fix0_out_valid"}, out_valid, 1'b0);
    chk({name, "_fix0_in_ready"}, in_ready, 1'b0);
    chk({name, "_fix0_busy"}, busy, 1'b1);
    while (idx < SLICES && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk({name, "_first_out_valid"}, out_valid, 1'b1);
      if (stalled) begin
        chk({name, "_stall_slice"}, out_slice, h_slice);
        chk({name, "_stall_idx"}, out_idx, h_idx);
        chk({name, "_stall_last"}, out_last, h_last);
      end
      if (out_valid) begin
        chk({name, "_slice"}, out_slice, exp_blk[idx]);
        chk({name, "_idx"}, out_idx, idx[ZW-1:0]);
        chk({name, "_last"}, out_last, idx == SLICES - 1);
        chk({name, "_in_ready_out"}, in_ready, 1'b0);
        out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        stalled = !out_ready;
        h_slice = out_slice;
        h_idx = out_idx;
        h_last = out_last;
        if (out_ready) idx++;
      end else begin
        out_ready = 1'b0;
        stalled = 0;
      end
      @(posedge clk);
    end
    if (idx < SLICES) chk({name, "_rx_timeout"}, idx, SLICES);
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, "_done_in_ready"}, in_ready, 1'b1);
    chk({name, "_done_out_valid"}, out_valid, 1'b0);
    chk({name, "_done_busy"}, busy, 1'b0);
  endtask

  initial begin
    // reset values
    #12;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // all-zero block
    for (int z = 0; z < SLICES; z++) blk[z] = '0;
    run_block("zero", 0, 0);

    // single bit in slice 0
    for (int z = 0; z < SLICES; z++) blk[z] = '0;
    blk[0] = 25'h0000001;
    build_expected(0);
    chk("model_z0", exp_blk[0], 25'h0210843);
    chk("model_z1", exp_blk[1], 25'h1084210);
    run_block("bit_z0", 0, 0);

    // single bit in last slice: wrap-around through FIX0
    for (int z = 0; z < SLICES; z++) blk[z] = '0;
    blk[SLICES-1] = 25'h0000001;
    run_block("bit_z63", 0, 0);

    // even column parity: output equals input
    for (int z = 0; z < SLICES; z++) blk[z] = '0;
    blk[5] = 25'h0000021;
    run_block("even_par", 1, 0);

    // random block with input gaps and output stalls
    for (int z = 0; z < SLICES; z++) blk[z] = 25'($urandom);
    run_block("rand_stall", 1, 0);

    // reset mid-block, then a full random block
    for (int z = 0; z < SLICES; z++) blk[z] = 25'($urandom);
    send_beats(10, 0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_out_valid", out_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int z = 0; z < SLICES; z++) blk[z] = 25'($urandom);
    run_block("after_rst", 1, 0);

`ifdef THETA_BYPASS_EN
    for (int z = 0; z < SLICES; z++) blk[z] = 25'($urandom);
    run_block("bypass", 1, 1);
    for (int z = 0; z < SLICES; z++) blk[z] = 25'($urandom);
    run_block("no_bypass", 0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
